// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: execute-stage bundle between the pipeline and the HI/LO
// multiply/divide controller.
//   mdu_opE  : HI/LO-class operation held in E (3-bit code)
//   srcaE    : rs operand after forwarding
//   srcbE    : rt operand after forwarding
//   flushE   : E-stage flush
//   stallE   : stall request to the hazard unit
//   busy     : iteration engine running
//   hi_o/lo_o: architectural HI/LO registers
// master = pipeline side, slave = mdu_ctrl.
interface mdu_ctrl_if;
    logic [2:0]  mdu_opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        stallE;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output mdu_opE, srcaE, srcbE, flushE,
        input  stallE, busy, hi_o, lo_o
    );

    modport slave (
        input  mdu_opE, srcaE, srcbE, flushE,
        output stallE, busy, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the MIPS execute stage.
// Runs a 32-iteration shift-add multiplier or restoring divider on operand
// magnitudes, holds the instruction in E via stallE until the result is
// ready, then commits HI/LO. MTHI/MTLO write in a single cycle.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : mdu_ctrl_if.slave (mdu_opE, srcaE, srcbE, flushE in;
//         stallE, busy, hi_o, lo_o out)
module mdu_ctrl (
    input  logic     clk,
    input  logic     rst,
    mdu_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    mdu_op_t     op;

    logic [31:0] a_reg;      // multiplicand / dividend shift register
    logic [31:0] b_reg;      // multiplier shift register / divisor
    logic [63:0] acc;        // product, or {remainder, quotient}
    logic [4:0]  cnt;
    logic        div_mode;
    logic        neg_main;   // negate product / quotient
    logic        neg_rem;    // negate remainder
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_md;
    logic        is_div;
    logic        is_signed;
    logic        div_zero;
    logic        start;
    logic        mt_hi_wr;
    logic        mt_lo_wr;
    logic        last;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    logic [32:0] mul_sum;
    logic [63:0] mul_nx;
    logic [32:0] div_rsh;
    logic [32:0] div_diff;
    logic        div_qbit;
    logic [31:0] div_rem;
    logic [63:0] div_nx;
    logic [63:0] prod_fin;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;

    assign op = mdu_op_t'(bus.mdu_opE);

    // ---------------- decode ----------------
    always_comb begin
        is_md     = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (op)
            OP_MULT:  begin is_md = 1'b1; is_signed = 1'b1; end
            OP_MULTU: begin is_md = 1'b1; end
            OP_DIV:   begin is_md = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
            default:  begin end
        endcase
    end

    // A divide by zero never starts, so it never stalls and leaves HI/LO alone.
    assign div_zero = is_div && (bus.srcbE == '0);
    assign start    = (state == IDLE) && is_md && !bus.flushE && !div_zero;
    assign mt_hi_wr = (state == IDLE) && (op == OP_MTHI) && !bus.flushE;
    assign mt_lo_wr = (state == IDLE) && (op == OP_MTLO) && !bus.flushE;
    assign last     = (state == RUN) && (cnt == 5'd31) && !bus.flushE;

    // 32-bit magnitudes: |0x80000000| stays 0x80000000 as an unsigned value.
    assign a_abs = (is_signed && bus.srcaE[31]) ? (32'd0 - bus.srcaE) : bus.srcaE;
    assign b_abs = (is_signed && bus.srcbE[31]) ? (32'd0 - bus.srcbE) : bus.srcbE;

    // ---------------- iteration step ----------------
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (b_reg[0] ? {1'b0, a_reg} : 33'd0);
        mul_nx  = {mul_sum, acc[31:1]};
    end

    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits; the quotient bit enters acc[0].
    always_comb begin
        div_rsh  = {acc[63:32], a_reg[31]};
        div_diff = div_rsh - {1'b0, b_reg};
        div_qbit = (div_rsh >= {1'b0, b_reg});
        div_rem  = div_qbit ? div_diff[31:0] : div_rsh[31:0];
        div_nx   = {div_rem, acc[30:0], div_qbit};
    end

    // Sign fix-up of the final step's result, committed at the RUN->DONE edge.
    always_comb begin
        prod_fin = neg_main ? (64'd0 - mul_nx) : mul_nx;
        quot_fin = neg_main ? (32'd0 - div_nx[31:0]) : div_nx[31:0];
        rem_fin  = neg_rem  ? (32'd0 - div_nx[63:32]) : div_nx[63:32];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bus.stallE = 1'b0;
        bus.busy   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
                bus.stallE = start;
            end
            RUN: begin
                bus.stallE = 1'b1;
                bus.busy   = 1'b1;
                if (bus.flushE) begin
                    state_nx = IDLE;
                end else if (cnt == 5'd31) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start) begin
            a_reg    <= a_abs;
            b_reg    <= b_abs;
            acc      <= '0;
            cnt      <= '0;
            div_mode <= is_div;
            neg_main <= is_signed && (bus.srcaE[31] ^ bus.srcbE[31]);
            neg_rem  <= is_signed && is_div && bus.srcaE[31];
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            if (div_mode) begin
                acc   <= div_nx;
                a_reg <= {a_reg[30:0], 1'b0};
            end else begin
                acc   <= mul_nx;
                b_reg <= {1'b0, b_reg[31:1]};
            end
        end
    end

    // ---------------- HI/LO ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (last) begin
            if (div_mode) begin
                hi_q <= rem_fin;
                lo_q <= quot_fin;
            end else begin
                hi_q <= prod_fin[63:32];
                lo_q <= prod_fin[31:0];
            end
        end else begin
            if (mt_hi_wr) begin
                hi_q <= bus.srcaE;
            end
            if (mt_lo_wr) begin
                lo_q <= bus.srcaE;
            end
        end
    end

    assign bus.hi_o = hi_q;
    assign bus.lo_o = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven, hand-sequenced and randomized checks of
// mdu_ctrl against an arithmetic reference model of HI/LO and stall length.
module tb_mdu_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_ctrl_if bus();

    mdu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  dop;   // opcode presented during the DONE cycle
        logic [31:0] da;
        int          ns;    // expected stalled cycles
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Arithmetic reference: HI/LO after an operation and its stall length.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int ns);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        ns = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; {m_hi, m_lo} = p; ns = 33; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; ns = 33; end
            3'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0]; ns = 33;
            end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; ns = 33; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: begin end
        endcase
    endtask

    // Entered and left at posedge+1. Returns stalled-cycle count, HI/LO in
    // the first non-stalled cycle, and HI/LO one cycle later.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] dop, input logic [31:0] da, output int n,
                          output logic [31:0] hd, output logic [31:0] ld,
                          output logic [31:0] ha, output logic [31:0] la);
        bus.mdu_opE = op;
        bus.srcaE   = a;
        bus.srcbE   = b;
        bus.flushE  = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.stallE) break;
            n++;
            @(posedge clk); #1;
            if (!bus.stallE) begin
                bus.mdu_opE = dop;
                bus.srcaE   = da;
            end
        end
        hd = bus.hi_o;
        ld = bus.lo_o;
        @(posedge clk); #1;
        bus.mdu_opE = 3'd0;
        @(negedge clk);
        ha = bus.hi_o;
        la = bus.lo_o;
        @(posedge clk); #1;
    endtask

    task automatic check_run(input string tag, input int n, input int ns,
                             input logic [31:0] hd, input logic [31:0] ld,
                             input logic [31:0] ha, input logic [31:0] la,
                             input logic [31:0] ehi, input logic [31:0] elo);
        chk({tag, " stall_cycles"}, n, ns);
        if (ns == 33) begin
            chk({tag, " hi_done"}, hd, ehi);
            chk({tag, " lo_done"}, ld, elo);
        end
        chk({tag, " hi"}, ha, ehi);
        chk({tag, " lo"}, la, elo);
    endtask

    initial begin
        int          n;
        int          ns;
        logic [31:0] hd, ld, ha, la;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'h0, 33, 32'hFFFFFFFE, 32'h00000001};
        tbl[1] = '{3'd1, 32'hFFFFFFFD, 32'd7,        3'd1, 32'h0, 33, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        3'd3, 32'h0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{3'd4, 32'd100,      32'd7,        3'd4, 32'h0, 33, 32'd2,        32'd14};
        tbl[4] = '{3'd4, 32'd5,        32'd0,        3'd4, 32'h0, 0,  32'd2,        32'd14};
        tbl[5] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 3'd3, 32'h0, 33, 32'h0,        32'h80000000};
        tbl[6] = '{3'd1, 32'h80000000, 32'h80000000, 3'd1, 32'h0, 33, 32'h40000000, 32'h0};
        tbl[7] = '{3'd3, 32'd7,        32'hFFFFFFFE, 3'd3, 32'h0, 33, 32'd1,        32'hFFFFFFFD};
        tbl[8] = '{3'd2, 32'd2,        32'd3,        3'd5, 32'hDEAD, 33, 32'h0,     32'd6};
        tbl[9] = '{3'd3, 32'd9,        32'd0,        3'd3, 32'h0, 0,  32'h0,        32'd6};

        bus.mdu_opE = 3'd0;
        bus.srcaE   = '0;
        bus.srcbE   = '0;
        bus.flushE  = 1'b0;
        rst = 1'b1;
        #12;
        chk("reset hi", bus.hi_o, 32'h0);
        chk("reset lo", bus.lo_o, 32'h0);
        chk("reset stall", {31'd0, bus.stallE}, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- table vectors ----
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dop, tbl[i].da, n, hd, ld, ha, la);
            check_run($sformatf("vec%0d", i), n, tbl[i].ns, hd, ld, ha, la, tbl[i].hi, tbl[i].lo);
        end
        m_hi = 32'h0;
        m_lo = 32'd6;

        // ---- MTLO then MTHI on consecutive cycles ----
        bus.mdu_opE = 3'd6; bus.srcaE = 32'hAAAA;
        @(negedge clk);
        chk("mtlo stall", {31'd0, bus.stallE}, 32'd0);
        @(posedge clk); #1;
        bus.mdu_opE = 3'd5; bus.srcaE = 32'h5555;
        @(negedge clk);
        chk("mtlo lo", bus.lo_o, 32'hAAAA);
        chk("mthi stall", {31'd0, bus.stallE}, 32'd0);
        @(posedge clk); #1;
        bus.mdu_opE = 3'd0;
        @(negedge clk);
        chk("mthi hi", bus.hi_o, 32'h5555);
        m_hi = 32'h5555; m_lo = 32'hAAAA;
        @(posedge clk); #1;

        // ---- flush together with start ----
        bus.mdu_opE = 3'd1; bus.srcaE = 32'd4; bus.srcbE = 32'd5; bus.flushE = 1'b1;
        @(negedge clk);
        chk("flush_start stall", {31'd0, bus.stallE}, 32'd0);
        @(posedge clk); #1;
        bus.mdu_opE = 3'd0; bus.flushE = 1'b0;
        @(negedge clk);
        chk("flush_start busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_start lo", bus.lo_o, m_lo);
        @(posedge clk); #1;

        // ---- DIV 100/3 flushed on RUN cycle 10, then MTHI ----
        bus.mdu_opE = 3'd3; bus.srcaE = 32'd100; bus.srcbE = 32'd3;
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        bus.flushE = 1'b1;
        @(negedge clk);
        chk("flush10 busy_before", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        bus.flushE = 1'b0; bus.mdu_opE = 3'd0;
        @(negedge clk);
        chk("flush10 busy", {31'd0, bus.busy}, 32'd0);
        chk("flush10 stall", {31'd0, bus.stallE}, 32'd0);
        chk("flush10 hi", bus.hi_o, m_hi);
        chk("flush10 lo", bus.lo_o, m_lo);
        @(posedge clk); #1;
        bus.mdu_opE = 3'd5; bus.srcaE = 32'h1234;
        @(negedge clk);
        chk("flush10 mthi stall", {31'd0, bus.stallE}, 32'd0);
        @(posedge clk); #1;
        bus.mdu_opE = 3'd0;
        @(negedge clk);
        chk("flush10 mthi hi", bus.hi_o, 32'h1234);
        m_hi = 32'h1234;
        @(posedge clk); #1;

        // ---- flush on the last RUN cycle: abort wins ----
        bus.mdu_opE = 3'd2; bus.srcaE = 32'd9; bus.srcbE = 32'd9;
        @(posedge clk); #1;
        repeat (31) begin @(posedge clk); #1; end
        bus.flushE = 1'b1;
        @(negedge clk);
        chk("flush31 busy_before", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        bus.flushE = 1'b0; bus.mdu_opE = 3'd0;
        @(negedge clk);
        chk("flush31 busy", {31'd0, bus.busy}, 32'd0);
        chk("flush31 hi", bus.hi_o, m_hi);
        chk("flush31 lo", bus.lo_o, m_lo);
        @(posedge clk); #1;

        // ---- randomized operations against the reference model ----
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'd0 - 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) ra = 32'($urandom_range(0, 200));
            model_op(rop, ra, rb, ns);
            run_op(rop, ra, rb, rop, ra, n, hd, ld, ha, la);
            check_run($sformatf("rnd%0d op%0d", i, rop), n, ns, hd, ld, ha, la, m_hi, m_lo);
        end

        // ---- asynchronous reset in the middle of RUN ----
        bus.mdu_opE = 3'd2; bus.srcaE = 32'hFFFF; bus.srcbE = 32'hFFFF;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk); #2;
        bus.mdu_opE = 3'd0;
        rst = 1'b1;
        #1;
        chk("async_rst hi", bus.hi_o, 32'h0);
        chk("async_rst lo", bus.lo_o, 32'h0);
        chk("async_rst stall", {31'd0, bus.stallE}, 32'd0);
        chk("async_rst busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
